mmio_ctrl: RTL and testbench

//  Memory-mapped I/O controller beside the EX stage. Decodes the EX ALU address of each

---
 rtl/mmio_ctrl_pkg.sv | 21 ++
 rtl/mmio_uart_tx_buf.sv | 67 ++++++
 rtl/mmio_ctrl.sv | 111 +++++++++++
 tb/tb_mmio_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_ctrl_pkg.sv
// rtl/mmio_ctrl_pkg.sv - shared constants for the MMIO controller: window nibble, register offsets, TX FSM states
// No ports; imported by mmio_ctrl and mmio_uart_tx_buf.
package mmio_ctrl_pkg;

    // Default addr[31:28] value of the I/O window.
    localparam logic [3:0] IO_BASE_NIB_DFLT = 4'h8;

    // Register offsets as word indices, i.e. addr[4:2].
    localparam logic [2:0] OFF_STATUS = 3'd0;  // 0x00 R
    localparam logic [2:0] OFF_RX     = 3'd1;  // 0x04 R
    localparam logic [2:0] OFF_TX     = 3'd2;  // 0x08 W
    localparam logic [2:0] OFF_CYC    = 3'd4;  // 0x10 R
    localparam logic [2:0] OFF_INST   = 3'd5;  // 0x14 R
    localparam logic [2:0] OFF_CLR    = 3'd6;  // 0x18 W

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_FULL = 1'b1
    } tx_state_e;

endpackage

// File: rtl/mmio_uart_tx_buf.sv
// rtl/mmio_uart_tx_buf.sv - one-entry UART TX byte buffer with sticky overrun flag
// Ports:
//   clk, rst      core clock, asynchronous active-high reset
//   wr_en         accepted store to the TX register this cycle
//   wr_data       byte to transmit
//   ovr_clr       status register read this cycle; clears the overrun flag
//   tx_data       byte presented to the transmitter
//   tx_valid      byte valid, held until tx_ready
//   tx_ready      transmitter handshake
//   idle          buffer empty (status tx_ready bit)
//   ovr           sticky overrun: a byte was written while the buffer was full
module mmio_uart_tx_buf
    import mmio_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       ovr_clr,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       idle,
    output logic       ovr
);

    tx_state_e state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= TX_IDLE;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            ovr      <= 1'b0;
        end else begin
            // Status reads and TX stores are never in the same access, so the
            // set below cannot collide with a clear in practice.
            if (ovr_clr) begin
                ovr <= 1'b0;
            end
            case (state)
                TX_IDLE: begin
                    if (wr_en) begin
                        tx_data  <= wr_data;
                        tx_valid <= 1'b1;
                        state    <= TX_FULL;
                    end
                end
                TX_FULL: begin
                    // A write while full is dropped even if the handshake
                    // completes in the same cycle.
                    if (wr_en) begin
                        ovr <= 1'b1;
                    end
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= TX_IDLE;
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

    assign idle = (state == TX_IDLE);

endmodule

// File: rtl/mmio_ctrl.sv
// rtl/mmio_ctrl.sv - EX-stage MMIO controller: I/O window decode, UART handshakes, cycle/instret counters
// Ports:
//   clk, rst                      core clock, asynchronous active-high reset
//   stall_i                       pipeline hold; blocks access, holds read outputs
//   ex_addr_i, ex_wdata_i         EX byte address and forwarded store data
//   ex_load_i, ex_store_i         EX instruction kind
//   retire_i                      one instruction retired this cycle
//   io_hit_o                      comb: address in the I/O window
//   io_sel_o, io_rdata_o          registered MEM-stage read select and data
//   uart_tx_data_o/valid_o/ready_i  transmitter stream
//   uart_rx_data_i/valid_i/ready_o  receiver stream (ready is a one-cycle pop)
module mmio_ctrl
    import mmio_ctrl_pkg::*;
#(
    parameter logic [3:0] IO_BASE_NIB = IO_BASE_NIB_DFLT,
    parameter int         CNT_W       = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic [31:0] ex_addr_i,
    input  logic [31:0] ex_wdata_i,
    input  logic        ex_load_i,
    input  logic        ex_store_i,
    input  logic        retire_i,
    output logic        io_hit_o,
    output logic        io_sel_o,
    output logic [31:0] io_rdata_o,
    output logic [7:0]  uart_tx_data_o,
    output logic        uart_tx_valid_o,
    input  logic        uart_tx_ready_i,
    input  logic [7:0]  uart_rx_data_i,
    input  logic        uart_rx_valid_i,
    output logic        uart_rx_ready_o
);

    logic             access;
    logic             rd;
    logic             wr;
    logic [2:0]       off;
    logic             tx_idle;
    logic             ovr;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] inst_cnt;
    logic [31:0]      rdata_nxt;
    logic             unused_bits;

    assign io_hit_o = (ex_addr_i[31:28] == IO_BASE_NIB);
    assign access   = (ex_load_i | ex_store_i) & io_hit_o & ~stall_i;
    assign rd       = access & ex_load_i;
    assign wr       = access & ex_store_i;
    assign off      = ex_addr_i[4:2];

    // Only word offsets and the TX byte matter; the rest of the bus is ignored.
    assign unused_bits = ^{ex_addr_i[27:5], ex_addr_i[1:0], ex_wdata_i[31:8]};

    mmio_uart_tx_buf u_tx_buf (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr && off == OFF_TX),
        .wr_data  (ex_wdata_i[7:0]),
        .ovr_clr  (rd && off == OFF_STATUS),
        .tx_data  (uart_tx_data_o),
        .tx_valid (uart_tx_valid_o),
        .tx_ready (uart_tx_ready_i),
        .idle     (tx_idle),
        .ovr      (ovr)
    );

    // Counters are sampled before this cycle's increment/clear takes effect.
    always_comb begin
        rdata_nxt = 32'h0;
        case (off)
            OFF_STATUS: rdata_nxt = {29'b0, ovr, uart_rx_valid_i, tx_idle};
            OFF_RX:     rdata_nxt = {24'b0, uart_rx_data_i};
            OFF_CYC:    rdata_nxt = 32'(cyc_cnt);
            OFF_INST:   rdata_nxt = 32'(inst_cnt);
            default:    rdata_nxt = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io_sel_o        <= 1'b0;
            io_rdata_o      <= 32'h0;
            uart_rx_ready_o <= 1'b0;
            cyc_cnt         <= '0;
            inst_cnt        <= '0;
        end else begin
            // Pop only when a byte was actually present at the access edge.
            uart_rx_ready_o <= rd && (off == OFF_RX) && uart_rx_valid_i;

            if (access) begin
                io_sel_o   <= ex_load_i;
                io_rdata_o <= rdata_nxt;
            end else if (!stall_i) begin
                io_sel_o <= 1'b0;
            end

            // Clear beats the same-cycle increment.
            if (wr && off == OFF_CLR) begin
                cyc_cnt  <= '0;
                inst_cnt <= '0;
            end else begin
                cyc_cnt  <= cyc_cnt + CNT_W'(1);
                inst_cnt <= inst_cnt + CNT_W'(retire_i);
            end
        end
    end

endmodule

// File: tb/tb_mmio_ctrl.sv
// tb/tb_mmio_ctrl.sv - scoreboard bench for mmio_ctrl (32-bit and 4-bit counter instances)
module tb_mmio_ctrl;

    localparam logic [31:0] A_STATUS = 32'h8000_0000;
    localparam logic [31:0] A_RX     = 32'h8000_0004;
    localparam logic [31:0] A_TX     = 32'h8000_0008;
    localparam logic [31:0] A_CYC    = 32'h8000_0010;
    localparam logic [31:0] A_INST   = 32'h8000_0014;
    localparam logic [31:0] A_CLR    = 32'h8000_0018;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic        ex_load;
    logic        ex_store;
    logic        retire;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;

    logic        io_hit, io_sel, tx_valid, rx_ready;
    logic [31:0] io_rdata;
    logic [7:0]  tx_data;
    logic        w_io_hit, w_io_sel, w_tx_valid, w_rx_ready;
    logic [31:0] w_io_rdata;
    logic [7:0]  w_tx_data;

    int n_chk  = 0;
    int n_fail = 0;
    int tb_cyc = 0;

    typedef struct {
        int          due;
        string       tag;
        logic [31:0] exp;
        logic [31:0] exp_w;
    } sb_t;

    sb_t sb_q[$];
    sb_t mon_e;

    mmio_ctrl dut (
        .clk(clk), .rst(rst), .stall_i(stall), .ex_addr_i(ex_addr), .ex_wdata_i(ex_wdata),
        .ex_load_i(ex_load), .ex_store_i(ex_store), .retire_i(retire),
        .io_hit_o(io_hit), .io_sel_o(io_sel), .io_rdata_o(io_rdata),
        .uart_tx_data_o(tx_data), .uart_tx_valid_o(tx_valid), .uart_tx_ready_i(tx_ready),
        .uart_rx_data_i(rx_data), .uart_rx_valid_i(rx_valid), .uart_rx_ready_o(rx_ready)
    );

    mmio_ctrl #(.CNT_W(4)) dut_w (
        .clk(clk), .rst(rst), .stall_i(stall), .ex_addr_i(ex_addr), .ex_wdata_i(ex_wdata),
        .ex_load_i(ex_load), .ex_store_i(ex_store), .retire_i(retire),
        .io_hit_o(w_io_hit), .io_sel_o(w_io_sel), .io_rdata_o(w_io_rdata),
        .uart_tx_data_o(w_tx_data), .uart_tx_valid_o(w_tx_valid), .uart_tx_ready_i(tx_ready),
        .uart_rx_data_i(rx_data), .uart_rx_valid_i(rx_valid), .uart_rx_ready_o(w_rx_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, tb_cyc);
        end
    endtask

    // Read results land on the negedge after the access edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0 && sb_q[0].due == tb_cyc) begin
            mon_e = sb_q.pop_front();
            check({mon_e.tag, "_sel"}, 32'(io_sel), 32'd1);
            check(mon_e.tag, io_rdata, mon_e.exp);
            check({mon_e.tag, "_w"}, w_io_rdata, mon_e.exp_w);
        end
    end

    task automatic io_load(input logic [31:0] addr, input logic [31:0] exp,
                           input logic [31:0] exp_w, input string tag);
        ex_addr = addr;
        ex_load = 1'b1;
        #1;
        check({tag, "_hit"}, 32'(io_hit), 32'd1);
        sb_q.push_back('{due: tb_cyc + 1, tag: tag, exp: exp, exp_w: exp_w});
        @(negedge clk);
        ex_load = 1'b0;
        ex_addr = 32'h0;
    endtask

    task automatic io_store(input logic [31:0] addr, input logic [31:0] data);
        ex_addr  = addr;
        ex_wdata = data;
        ex_store = 1'b1;
        @(negedge clk);
        ex_store = 1'b0;
        ex_addr  = 32'h0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sel"}, 32'(io_sel), 32'd0);
        check({tag, "_rdata"}, io_rdata, 32'd0);
        check({tag, "_txv"}, 32'(tx_valid), 32'd0);
        check({tag, "_txd"}, 32'(tx_data), 32'd0);
        check({tag, "_rxr"}, 32'(rx_ready), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; stall = 1'b0; ex_addr = 32'h0; ex_wdata = 32'h0;
        ex_load = 1'b0; ex_store = 1'b0; retire = 1'b0;
        tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("rst_init");
        rst = 1'b0;

        // TX with a slow transmitter: valid held 6 cycles
        io_store(A_TX, 32'h0000_0041);
        for (int i = 0; i < 5; i++) begin
            check("tx_hold_valid", 32'(tx_valid), 32'd1);
            check("tx_hold_data", 32'(tx_data), 32'h41);
            @(negedge clk);
        end
        tx_ready = 1'b1;
        check("tx_hs_valid", 32'(tx_valid), 32'd1);
        @(negedge clk);
        tx_ready = 1'b0;
        check("tx_after_hs", 32'(tx_valid), 32'd0);
        io_load(A_STATUS, 32'h1, 32'h1, "stat_idle");

        // Overrun: back-to-back stores while full
        io_store(A_TX, 32'h41);
        io_store(A_TX, 32'h42);
        io_load(A_STATUS, 32'h4, 32'h4, "stat_ovr");
        io_load(A_STATUS, 32'h0, 32'h0, "stat_ovr_clr");
        check("ovr_kept_byte", 32'(tx_data), 32'h41);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        io_load(A_STATUS, 32'h1, 32'h1, "stat_drain");

        // Store while full in the same cycle as the handshake
        io_store(A_TX, 32'h43);
        ex_addr = A_TX; ex_wdata = 32'h44; ex_store = 1'b1; tx_ready = 1'b1;
        @(negedge clk);
        ex_store = 1'b0; tx_ready = 1'b0; ex_addr = 32'h0;
        check("hs_ovr_valid", 32'(tx_valid), 32'd0);
        io_load(A_STATUS, 32'h5, 32'h5, "stat_hs_ovr");
        io_load(A_STATUS, 32'h1, 32'h1, "stat_hs_clr");

        // RX pop and no-pop reads
        rx_valid = 1'b1; rx_data = 8'h5A;
        check("rx_ready_pre", 32'(rx_ready), 32'd0);
        io_load(A_RX, 32'h5A, 32'h5A, "rx_byte");
        check("rx_pop", 32'(rx_ready), 32'd1);
        @(negedge clk);
        check("rx_pop_end", 32'(rx_ready), 32'd0);
        io_load(A_STATUS, 32'h3, 32'h3, "stat_rx");
        check("stat_no_pop", 32'(rx_ready), 32'd0);
        rx_valid = 1'b0; rx_data = 8'h33;
        io_load(A_RX, 32'h33, 32'h33, "rx_empty");
        check("rx_empty_no_pop", 32'(rx_ready), 32'd0);

        // Unmapped offsets and write-only registers read zero
        io_load(32'h8000_000C, 32'h0, 32'h0, "unmapped_0c");
        io_store(32'h8000_001C, 32'h99);
        io_load(A_TX, 32'h0, 32'h0, "tx_reg_read");

        // Counters: clear, pre-increment reads, retire count, 4-bit wrap
        io_store(A_CLR, 32'h0);
        io_load(A_CYC, 32'd0, 32'd0, "cyc_clr0");
        io_load(A_INST, 32'd0, 32'd0, "inst_clr0");
        io_load(A_CYC, 32'd2, 32'd2, "cyc_clr2");
        io_store(A_CLR, 32'h0);
        for (int i = 0; i < 100; i++) begin
            retire = (i < 74) && (i % 2 == 0);
            @(negedge clk);
        end
        retire = 1'b0;
        io_load(A_CYC, 32'd100, 32'd4, "cyc_100");
        io_load(A_INST, 32'd37, 32'd5, "inst_37");
        io_store(A_CLR, 32'h0);
        repeat (16) @(negedge clk);
        io_load(A_CYC, 32'd16, 32'd0, "cyc_wrap");
        retire = 1'b1;
        io_store(A_CLR, 32'h0);
        retire = 1'b0;
        io_load(A_INST, 32'd0, 32'd0, "clr_beats_inc");

        // Stall blocks access and holds read outputs
        io_load(A_STATUS, 32'h1, 32'h1, "stat_prestall");
        stall = 1'b1;
        ex_addr = A_TX; ex_wdata = 32'h77; ex_store = 1'b1;
        repeat (2) @(negedge clk);
        ex_store = 1'b0;
        ex_addr = A_RX; rx_valid = 1'b1; rx_data = 8'h11; ex_load = 1'b1;
        repeat (2) @(negedge clk);
        check("stall_no_tx", 32'(tx_valid), 32'd0);
        check("stall_no_pop", 32'(rx_ready), 32'd0);
        check("stall_sel_hold", 32'(io_sel), 32'd1);
        check("stall_rdata_hold", io_rdata, 32'h1);
        ex_load = 1'b0; rx_valid = 1'b0; ex_addr = 32'h0; stall = 1'b0;
        @(negedge clk);
        check("idle_sel_drop", 32'(io_sel), 32'd0);
        io_load(A_STATUS, 32'h1, 32'h1, "stat_poststall");

        // Accesses outside the window
        ex_addr = 32'h1000_0000; ex_load = 1'b1;
        #1;
        check("dmem_hit", 32'(io_hit), 32'd0);
        @(negedge clk);
        ex_load = 1'b0;
        check("dmem_sel", 32'(io_sel), 32'd0);
        io_store(32'h1000_0008, 32'h55);
        check("dmem_store_no_tx", 32'(tx_valid), 32'd0);

        // Asynchronous reset while a byte is pending
        io_store(A_TX, 32'h66);
        check("pre_rst_valid", 32'(tx_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("rst_async");
        @(negedge clk);
        rst = 1'b0;
        io_load(A_STATUS, 32'h1, 32'h1, "stat_post_rst");
        io_load(A_CYC, 32'd1, 32'd1, "cyc_post_rst");

        repeat (2) @(negedge clk);
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
